// File: rtl/lcd_bus_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_writer
// Brief    : Buffers 24-bit pixels and command bytes and serialises them onto
//            the ILI9486 8-bit 8080-I write bus. Define LCD_RGB565_EN for
//            2-byte RGB565 pixels (default is 3-byte RGB666).
// Revision : 1.0  initial release
// ============================================================================
module lcd_bus_writer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] pix_data,
    input  logic        pix_wr_en,
    output logic        pix_afull,
    input  logic [7:0]  cmd_byte,
    input  logic        cmd_is_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic        overflow,
    input  logic        ovf_clr,
    output logic        busy,
    output logic        lcd_cs_n,
    output logic        lcd_dc,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic [7:0]  lcd_db
);

    localparam int c_AW      = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W   = c_AW + 1;
    localparam int c_MAX_CYC = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int c_PH_W    = $clog2(c_MAX_CYC) + 1;
`ifdef LCD_RGB565_EN
    localparam int c_BPP     = 2;
`else
    localparam int c_BPP     = 3;
`endif
    localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_AFULL     = c_CNT_W'(FIFO_DEPTH - 2);
    localparam logic [c_PH_W-1:0]  c_LOW_LAST  = c_PH_W'(WR_LOW_CYC - 1);
    localparam logic [c_PH_W-1:0]  c_HIGH_LAST = c_PH_W'(WR_HIGH_CYC - 1);
    localparam logic [1:0]         c_SEL_LAST  = 2'(c_BPP - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_WR_LOW   = 3'd2,
        ST_WR_HIGH  = 3'd3,
        ST_CS_HOLD  = 3'd4
    } state_t;

    function automatic logic [7:0] pix_byte(input logic [23:0] pix, input logic [1:0] sel);
`ifdef LCD_RGB565_EN
        pix_byte = (sel == 2'd0) ? {pix[23:19], pix[15:13]} : {pix[12:10], pix[7:3]};
`else
        case (sel)
            2'd0:    pix_byte = pix[23:16];
            2'd1:    pix_byte = pix[15:8];
            default: pix_byte = pix[7:0];
        endcase
`endif
    endfunction

    // ------------------------------------------------------------------
    // Pixel FIFO
    // ------------------------------------------------------------------
    logic [23:0]        r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_next;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic [23:0]        w_fifo_head;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_FULL);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push      = pix_wr_en && (!w_full || w_pop);
    assign w_drop      = pix_wr_en && w_full && !w_pop;
    assign w_fifo_head = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_W'(1);
            2'b01:   w_count_next = r_count - c_CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= w_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Write-cycle sequencer
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [c_PH_W-1:0]  r_phase;
    logic [c_PH_W-1:0]  w_phase_next;
    logic [23:0]        r_pix;
    logic [23:0]        w_pix_next;
    logic [1:0]         r_sel;
    logic [1:0]         w_sel_next;
    logic               r_is_cmd;
    logic               w_is_cmd_next;
    logic [7:0]         r_cmd_byte;
    logic               r_cmd_dc;
    logic               w_accept;
    logic               w_enter_low;
    logic [7:0]         w_db_next;
    logic               w_dc_next;

    logic               r_cs_n;
    logic               r_wr_n;
    logic               r_rd_n;
    logic               r_dc;
    logic [7:0]         r_db;
    logic               r_cmd_ready;
    logic               r_busy;
    logic               r_afull;
    logic               r_overflow;

    always_comb begin
        w_state_next  = r_state;
        w_phase_next  = r_phase;
        w_pix_next    = r_pix;
        w_sel_next    = r_sel;
        w_is_cmd_next = r_is_cmd;
        w_pop         = 1'b0;
        w_accept      = 1'b0;
        w_enter_low   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // cmd_ready already implies an empty FIFO, so a command never overtakes pixels.
                if (cmd_valid && r_cmd_ready) begin
                    w_accept      = 1'b1;
                    w_is_cmd_next = 1'b1;
                    w_state_next  = ST_CS_SETUP;
                end else if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_pix_next    = w_fifo_head;
                    w_sel_next    = 2'd0;
                    w_is_cmd_next = 1'b0;
                    w_state_next  = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                w_phase_next = '0;
                w_enter_low  = 1'b1;
                w_state_next = ST_WR_LOW;
            end
            ST_WR_LOW: begin
                if (r_phase == c_LOW_LAST) begin
                    w_phase_next = '0;
                    w_state_next = ST_WR_HIGH;
                end else begin
                    w_phase_next = r_phase + c_PH_W'(1);
                end
            end
            ST_WR_HIGH: begin
                if (r_phase == c_HIGH_LAST) begin
                    w_phase_next = '0;
                    if (!r_is_cmd && (r_sel != c_SEL_LAST)) begin
                        w_sel_next   = r_sel + 2'd1;
                        w_enter_low  = 1'b1;
                        w_state_next = ST_WR_LOW;
                    end else if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_pix_next    = w_fifo_head;
                        w_sel_next    = 2'd0;
                        w_is_cmd_next = 1'b0;
                        w_enter_low   = 1'b1;
                        w_state_next  = ST_WR_LOW;
                    end else begin
                        w_state_next = ST_CS_HOLD;
                    end
                end else begin
                    w_phase_next = r_phase + c_PH_W'(1);
                end
            end
            ST_CS_HOLD: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_db_next = w_is_cmd_next ? r_cmd_byte : pix_byte(w_pix_next, w_sel_next);
    assign w_dc_next = w_is_cmd_next ? r_cmd_dc : 1'b1;

    // Pins are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_pix       <= '0;
            r_sel       <= 2'd0;
            r_is_cmd    <= 1'b0;
            r_cmd_byte  <= 8'd0;
            r_cmd_dc    <= 1'b0;
            r_cs_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_rd_n      <= 1'b1;
            r_dc        <= 1'b1;
            r_db        <= 8'd0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_afull     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_phase  <= w_phase_next;
            r_pix    <= w_pix_next;
            r_sel    <= w_sel_next;
            r_is_cmd <= w_is_cmd_next;
            if (w_accept) begin
                r_cmd_byte <= cmd_byte;
                r_cmd_dc   <= cmd_is_data;
            end
            r_cs_n <= (w_state_next == ST_IDLE);
            r_wr_n <= (w_state_next != ST_WR_LOW);
            r_rd_n <= 1'b1;
            if (w_enter_low) begin
                r_db <= w_db_next;
                r_dc <= w_dc_next;
            end
            r_cmd_ready <= (w_state_next == ST_IDLE) && (w_count_next == '0);
            r_busy      <= (w_state_next != ST_IDLE) || (w_count_next != '0);
            r_afull     <= (w_count_next >= c_AFULL);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign lcd_cs_n  = r_cs_n;
    assign lcd_wr_n  = r_wr_n;
    assign lcd_rd_n  = r_rd_n;
    assign lcd_dc    = r_dc;
    assign lcd_db    = r_db;
    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign pix_afull = r_afull;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bus_writer
// Brief    : Directed self-checking bench for lcd_bus_writer (default RGB666
//            build; LCD_RGB565_EN selects the 2-byte expectations).
// Revision : 1.0  initial release
// ============================================================================
module tb_lcd_bus_writer;

`ifdef LCD_RGB565_EN
    localparam int c_BPP        = 2;
    localparam int c_FIRST_DROP = 19;
`else
    localparam int c_BPP        = 3;
    localparam int c_FIRST_DROP = 18;
`endif
    localparam int c_BYTE_PER = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] pix_data;
    logic        pix_wr_en;
    logic        pix_afull;
    logic [7:0]  cmd_byte;
    logic        cmd_is_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        overflow;
    logic        ovf_clr;
    logic        busy;
    logic        lcd_cs_n;
    logic        lcd_dc;
    logic        lcd_wr_n;
    logic        lcd_rd_n;
    logic [7:0]  lcd_db;

    lcd_bus_writer #(
        .FIFO_DEPTH  (16),
        .WR_LOW_CYC  (2),
        .WR_HIGH_CYC (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_data    (pix_data),
        .pix_wr_en   (pix_wr_en),
        .pix_afull   (pix_afull),
        .cmd_byte    (cmd_byte),
        .cmd_is_data (cmd_is_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .busy        (busy),
        .lcd_cs_n    (lcd_cs_n),
        .lcd_dc      (lcd_dc),
        .lcd_wr_n    (lcd_wr_n),
        .lcd_rd_n    (lcd_rd_n),
        .lcd_db      (lcd_db)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [23:0] p, input int k);
`ifdef LCD_RGB565_EN
        if (k == 0) return {p[23:19], p[15:13]};
        return {p[12:10], p[7:3]};
`else
        if (k == 0) return p[23:16];
        if (k == 1) return p[15:8];
        return p[7:0];
`endif
    endfunction

    function automatic logic [23:0] pat16(input int i);
        return 24'(24'h112233 + i * 24'h010305);
    endfunction

    function automatic logic [23:0] pat20(input int i);
        return 24'(24'hA0B0C0 ^ (i * 24'h0F0701));
    endfunction

    // Bus monitor: latches {dc,db} at each wr_n rise and measures pulse/frame widths.
    logic [8:0] bytes_q [$];
    int         wr_w_q  [$];
    int         cs_w_q  [$];
    int         fall_q  [$];
    int         n_falls = 0;
    int         cyc     = 0;
    logic       prev_wr = 1'b1;
    logic       prev_cs = 1'b1;
    int         wr_lo   = 0;
    int         cs_lo   = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_wr = 1'b1;
            prev_cs = 1'b1;
            wr_lo   = 0;
            cs_lo   = 0;
        end else begin
            if (!lcd_wr_n) wr_lo++;
            if (!lcd_cs_n) cs_lo++;
            if (prev_wr && !lcd_wr_n) begin
                fall_q.push_back(cyc);
                n_falls++;
            end
            if (!prev_wr && lcd_wr_n) begin
                bytes_q.push_back({lcd_dc, lcd_db});
                wr_w_q.push_back(wr_lo);
                wr_lo = 0;
            end
            if (!prev_cs && lcd_cs_n) begin
                cs_w_q.push_back(cs_lo);
                cs_lo = 0;
            end
            prev_wr = lcd_wr_n;
            prev_cs = lcd_cs_n;
        end
    end

    task automatic clear_mon();
        bytes_q.delete();
        wr_w_q.delete();
        cs_w_q.delete();
        fall_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while ((busy || !cmd_ready || !lcd_cs_n) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(k < budget), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first_af;
        int          mism;
        int          k;
        int          f0;
        logic [8:0]  exp_q [$];

        rst_n       = 1'b0;
        pix_data    = 24'd0;
        pix_wr_en   = 1'b0;
        cmd_byte    = 8'd0;
        cmd_is_data = 1'b0;
        cmd_valid   = 1'b0;
        ovf_clr     = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_cs_n",      lcd_cs_n,  1);
        check("rst_wr_n",      lcd_wr_n,  1);
        check("rst_rd_n",      lcd_rd_n,  1);
        check("rst_dc",        lcd_dc,    1);
        check("rst_db",        lcd_db,    0);
        check("rst_overflow",  overflow,  0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy",      busy,      0);
        check("rst_afull",     pix_afull, 0);

        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);

        // Single command 0x2C
        clear_mon();
        cmd_byte = 8'h2C; cmd_is_data = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_ready_drop", cmd_ready, 0);
        check("cmd_cs_setup",   lcd_cs_n,  0);
        check("cmd_wr_setup",   lcd_wr_n,  1);
        @(negedge clk);
        check("cmd_wr_low", lcd_wr_n, 0);
        check("cmd_db",     lcd_db,   8'h2C);
        check("cmd_dc",     lcd_dc,   0);
        wait_idle("cmd_idle_timeout", 100);
        check("cmd_nbytes",   bytes_q.size(), 1);
        check("cmd_byte_lat", bytes_q[0],     {1'b0, 8'h2C});
        check("cmd_wr_width", wr_w_q[0],      2);
        check("cmd_cs_width", cs_w_q[0],      6);

        // Single pixel 0xFC8004
        clear_mon();
        pix_data = 24'hFC8004; pix_wr_en = 1'b1;
        @(negedge clk);
        pix_wr_en = 1'b0;
        check("pix_e0_cs_n", lcd_cs_n, 1);
        check("pix_e0_busy", busy,     1);
        @(negedge clk);
        check("pix_e1_cs_n", lcd_cs_n, 0);
        check("pix_e1_wr_n", lcd_wr_n, 1);
        @(negedge clk);
        check("pix_e2_wr_n", lcd_wr_n, 0);
        check("pix_e2_db",   lcd_db,   exp_byte(24'hFC8004, 0));
        wait_idle("pix_idle_timeout", 100);
        check("pix_nbytes", bytes_q.size(), c_BPP);
        mism = 0;
        for (int b = 0; b < c_BPP; b++) begin
            if (bytes_q[b] !== {1'b1, exp_byte(24'hFC8004, b)}) mism++;
            if (wr_w_q[b] != 2) mism++;
            if (b > 0 && (fall_q[b] - fall_q[b-1]) != c_BYTE_PER) mism++;
        end
        check("pix_bytes_timing", mism, 0);
        check("pix_cs_frames", cs_w_q.size(), 1);
        check("pix_cs_width",  cs_w_q[0],     2 + c_BPP * c_BYTE_PER);

        // 16 back-to-back pixels
        clear_mon();
        first_af = -1;
        for (int i = 0; i < 16; i++) begin
            pix_data = pat16(i); pix_wr_en = 1'b1;
            @(negedge clk);
            if (pix_afull && first_af < 0) first_af = i;
        end
        pix_wr_en = 1'b0;
        check("p16_afull_idx", first_af, 15);
        check("p16_overflow",  overflow, 0);
        wait_idle("p16_idle_timeout", 1000);
        check("p16_nbytes", bytes_q.size(), 16 * c_BPP);
        mism = 0;
        for (int i = 0; i < 16; i++)
            for (int b = 0; b < c_BPP; b++)
                if (bytes_q[i * c_BPP + b] !== {1'b1, exp_byte(pat16(i), b)}) mism++;
        check("p16_bytes", mism, 0);
        check("p16_cs_frames", cs_w_q.size(), 1);
        check("p16_cs_width",  cs_w_q[0],     2 + 16 * c_BPP * c_BYTE_PER);

        // 20 back-to-back pixels: overflow, dropped words, clear collision
        clear_mon();
        for (int i = 0; i < 20; i++) begin
            pix_data = pat20(i); pix_wr_en = 1'b1;
            ovf_clr  = (i == c_FIRST_DROP);
            @(negedge clk);
            if (i == c_FIRST_DROP - 1) check("p20_ovf_before", overflow, 0);
            if (i == c_FIRST_DROP)     check("p20_ovf_set_wins", overflow, 1);
        end
        pix_wr_en = 1'b0;
        ovf_clr   = 1'b0;
        wait_idle("p20_idle_timeout", 1000);
        check("p20_ovf_sticky", overflow, 1);
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            if (i < c_FIRST_DROP)
                for (int b = 0; b < c_BPP; b++) exp_q.push_back({1'b1, exp_byte(pat20(i), b)});
        end
        check("p20_nbytes", bytes_q.size(), exp_q.size());
        mism = 0;
        for (int j = 0; j < exp_q.size(); j++)
            if (bytes_q[j] !== exp_q[j]) mism++;
        check("p20_bytes", mism, 0);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("p20_ovf_clr", overflow, 0);

        // Command held while 5 pixels are buffered
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            pix_data = pat16(i + 3); pix_wr_en = 1'b1;
            @(negedge clk);
        end
        pix_wr_en = 1'b0;
        cmd_byte = 8'hA5; cmd_is_data = 1'b1; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("cq_wait_timeout", 32'(k < 400), 1);
        check("cq_bytes_before", bytes_q.size(), 5 * c_BPP);
        check("cq_cs_before",    lcd_cs_n, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cq_ready_drop", cmd_ready, 0);
        wait_idle("cq_idle_timeout", 200);
        check("cq_nbytes",    bytes_q.size(), 5 * c_BPP + 1);
        check("cq_cmd_byte",  bytes_q[5 * c_BPP], {1'b1, 8'hA5});
        check("cq_cs_frames", cs_w_q.size(), 2);
        check("cq_cs_w0",     cs_w_q[0], 2 + 5 * c_BPP * c_BYTE_PER);
        check("cq_cs_w1",     cs_w_q[1], 6);

        // Reset during the WR_LOW phase of the G byte
        clear_mon();
        f0 = n_falls;
        pix_data = 24'h123456; pix_wr_en = 1'b1;
        @(negedge clk);
        pix_wr_en = 1'b0;
        k = 0;
        while (n_falls < f0 + 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rstx_wait_timeout", 32'(k < 100), 1);
        check("rstx_in_low", lcd_wr_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rstx_wr_n", lcd_wr_n, 1);
        check("rstx_cs_n", lcd_cs_n, 1);
        check("rstx_db",   lcd_db,   0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rstx_busy",  busy,      0);
        check("rstx_ready", cmd_ready, 1);
        f0 = n_falls;
        repeat (30) @(negedge clk);
        check("rstx_no_resume", n_falls, f0);
        check("rstx_cs_idle",   lcd_cs_n, 1);

`ifdef LCD_RGB565_EN
        clear_mon();
        pix_data = 24'hF8FC00; pix_wr_en = 1'b1;
        @(negedge clk);
        pix_wr_en = 1'b0;
        wait_idle("r565_idle_timeout", 100);
        check("r565_nbytes", bytes_q.size(), 2);
        check("r565_b0",     bytes_q[0], {1'b1, 8'hFF});
        check("r565_b1",     bytes_q[1], {1'b1, 8'hE0});
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
